io_controller: RTL

Memory-mapped I/O controller between the processor's data bus and the board peripherals: four keys, ten switches, ten red LEDs and the 16-bit hex-display value. It holds the writable HEX and LEDR registers, synchronizes and debounces KEY and SW, and keeps sticky ready/overrun status so software can poll for input changes. Its `hex_out` and `ledr_out` feed the existing seven-segment decode and LED pass-through logic at the board top level.

---
 rtl/io_controller.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/io_controller.sv
// Memory-mapped KEY/SW/LEDR/HEX controller.
// Synchronizes and debounces inputs and keeps sticky ready/overrun status.

module io_input_group #(
  parameter int W = 4,
  parameter int N = 10000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] raw,
  input  logic         data_read,
  input  logic         ctrl_clear,
  output logic [W-1:0] data,
  output logic         ready,
  output logic         overrun
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [W-1:0]  sync1;
  logic [W-1:0]  sync2;
  logic [W-1:0]  cand;
  logic [W-1:0]  cand_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          update;

  // two-flop synchronizer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // candidate tracking; update fires on the edge the count reaches N-1
  always_comb begin
    cand_next = cand;
    cnt_next  = cnt;
    if (sync2 != cand) begin
      cand_next = sync2;
      cnt_next  = '0;
    end else if (cand != data) begin
      cnt_next  = cnt + 1'b1;
    end
    update = (cand_next != data) && (cnt_next == LAST);
  end

  // debouncer and sticky status registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand    <= '0;
      cnt     <= '0;
      data    <= '0;
      ready   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      cand    <= cand_next;
      cnt     <= update ? '0 : cnt_next;
      if (update)
        data  <= cand_next;
      ready   <= update | (ready & ~data_read);
      overrun <= (update & ready & ~data_read)
               | (overrun & ~ctrl_clear);
    end
  end

endmodule

module io_controller #(
  parameter int DBITS = 32,
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter logic [DBITS-1:0] ADDR_HEX   = 32'hF0000000,
  parameter logic [DBITS-1:0] ADDR_LEDR  = 32'hF0000004,
  parameter logic [DBITS-1:0] ADDR_KDATA = 32'hF0000010,
  parameter logic [DBITS-1:0] ADDR_KCTRL = 32'hF0000110,
  parameter logic [DBITS-1:0] ADDR_SDATA = 32'hF0000014,
  parameter logic [DBITS-1:0] ADDR_SCTRL = 32'hF0000114
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] addr_in,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [DBITS-1:0] data_in,
  output logic [DBITS-1:0] data_out,
  input  logic [3:0]       key_in,
  input  logic [9:0]       sw_in,
  output logic [9:0]       ledr_out,
  output logic [15:0]      hex_out
);

  logic [15:0] hex;
  logic [9:0]  ledr;
  logic [3:0]  kdata;
  logic [9:0]  sdata;
  logic        krdy;
  logic        kovr;
  logic        srdy;
  logic        sovr;
  logic        kread;
  logic        sread;
  logic        kclr;
  logic        sclr;
  logic        unused_bits;

  assign unused_bits = ^data_in[DBITS-1:16];

  assign kread = rd_en && (addr_in == ADDR_KDATA);
  assign sread = rd_en && (addr_in == ADDR_SDATA);
  assign kclr  = wr_en && (addr_in == ADDR_KCTRL) && !data_in[1];
  assign sclr  = wr_en && (addr_in == ADDR_SCTRL) && !data_in[1];

  // writable output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hex  <= '0;
      ledr <= '0;
    end else if (wr_en) begin
      if (addr_in == ADDR_HEX)
        hex  <= data_in[15:0];
      if (addr_in == ADDR_LEDR)
        ledr <= data_in[9:0];
    end
  end

  assign hex_out  = hex;
  assign ledr_out = ledr;

  io_input_group #(
    .W (4),
    .N (DEBOUNCE_CYCLES)
  ) u_key (
    .clk        (clk),
    .reset      (reset),
    .raw        (~key_in),
    .data_read  (kread),
    .ctrl_clear (kclr),
    .data       (kdata),
    .ready      (krdy),
    .overrun    (kovr)
  );

  io_input_group #(
    .W (10),
    .N (DEBOUNCE_CYCLES)
  ) u_sw (
    .clk        (clk),
    .reset      (reset),
    .raw        (sw_in),
    .data_read  (sread),
    .ctrl_clear (sclr),
    .data       (sdata),
    .ready      (srdy),
    .overrun    (sovr)
  );

  // combinational read mux, unmapped addresses read as zero
  always_comb begin
    data_out = '0;
    unique case (1'b1)
      (addr_in == ADDR_HEX):   data_out = DBITS'(hex);
      (addr_in == ADDR_LEDR):  data_out = DBITS'(ledr);
      (addr_in == ADDR_KDATA): data_out = DBITS'(kdata);
      (addr_in == ADDR_KCTRL): data_out = DBITS'({kovr, krdy});
      (addr_in == ADDR_SDATA): data_out = DBITS'(sdata);
      (addr_in == ADDR_SCTRL): data_out = DBITS'({sovr, srdy});
      default:                 data_out = '0;
    endcase
  end

endmodule
